// File: rtl/vga_motion_gen.sv
// vga_motion_gen: moving test-object coordinates for the VGA test path.
// Each axis either wraps or bounces, and positions advance once per prescaled tick.
module vga_motion_gen #(
    parameter int COORD_W  = 16,
    parameter int X_MAX    = 640,
    parameter int Y_MAX    = 480,
    parameter int TICK_DIV = 840000,
    parameter int STEP_W   = 4
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               enable,
    input  logic               modeX,
    input  logic               modeY,
    input  logic [STEP_W-1:0]  stepX,
    input  logic [STEP_W-1:0]  stepY,
    input  logic               load,
    input  logic [COORD_W-1:0] loadX,
    input  logic [COORD_W-1:0] loadY,
    output logic [COORD_W-1:0] posX,
    output logic [COORD_W-1:0] posY,
    output logic               dirX,
    output logic               dirY,
    output logic               tick,
    output logic               edgeX,
    output logic               edgeY
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0]      PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [COORD_W-1:0] X_TOP    = COORD_W'(X_MAX - 1);
    localparam logic [COORD_W-1:0] Y_TOP    = COORD_W'(Y_MAX - 1);
    localparam logic [COORD_W:0]   X_LIM    = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0]   Y_LIM    = (COORD_W+1)'(Y_MAX);
    localparam logic [COORD_W:0]   X_END    = (COORD_W+1)'(X_MAX - 1);
    localparam logic [COORD_W:0]   Y_END    = (COORD_W+1)'(Y_MAX - 1);

    // Returns {next_pos, next_dir, edge_hit} for one axis.
    function automatic logic [COORD_W+1:0] axis_next(
        input logic [COORD_W-1:0] pos,
        input logic [STEP_W-1:0]  step,
        input logic               mode,
        input logic               dir,
        input logic [COORD_W:0]   lim,
        input logic [COORD_W:0]   top
    );
        logic [COORD_W:0] p, st, s;
        p  = {1'b0, pos};
        st = (COORD_W+1)'(step);
        s  = p + st;
        if (step == '0)
            axis_next = {pos, dir, 1'b0};
        else if (!mode)
            axis_next = (s >= lim) ? {COORD_W'(s - lim), dir, 1'b1} : {COORD_W'(s), dir, 1'b0};
        else if (!dir)
            axis_next = (s >= top) ? {COORD_W'((top << 1) - s), 2'b11} : {COORD_W'(s), 2'b00};
        else
            axis_next = (p <= st) ? {COORD_W'(st - p), 2'b01} : {COORD_W'(p - st), 2'b10};
    endfunction

    logic [PW-1:0]      pre;
    logic               fire;
    logic [COORD_W+1:0] nx, ny;

    assign fire = enable && pre == PRE_LAST;
    assign nx   = axis_next(posX, stepX, modeX, dirX, X_LIM, X_END);
    assign ny   = axis_next(posY, stepY, modeY, dirY, Y_LIM, Y_END);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pre   <= '0;
            posX  <= '0;
            posY  <= '0;
            dirX  <= 1'b0;
            dirY  <= 1'b0;
            tick  <= 1'b0;
            edgeX <= 1'b0;
            edgeY <= 1'b0;
        end else if (load) begin
            pre   <= '0;
            posX  <= loadX > X_TOP ? X_TOP : loadX;
            posY  <= loadY > Y_TOP ? Y_TOP : loadY;
            dirX  <= 1'b0;
            dirY  <= 1'b0;
            tick  <= 1'b0;
            edgeX <= 1'b0;
            edgeY <= 1'b0;
        end else begin
            pre   <= enable ? (fire ? '0 : pre + PW'(1)) : pre;
            tick  <= fire;
            edgeX <= fire & nx[0];
            edgeY <= fire & ny[0];
            if (fire) begin
                posX <= nx[COORD_W+1:2];
                dirX <= nx[1];
                posY <= ny[COORD_W+1:2];
                dirY <= ny[1];
            end
        end
    end
endmodule

// File: tb/tb_vga_motion_gen.sv
// tb_vga_motion_gen: directed stimulus with a per-cycle reference model and literal spot checks.
module tb_vga_motion_gen;
    localparam int CW = 16, XM = 10, YM = 8, TD = 4, SW = 4;

    logic          clk = 0, rstN = 0, enable = 0, modeX = 0, modeY = 0, load = 0;
    logic [SW-1:0] stepX = 0, stepY = 0;
    logic [CW-1:0] loadX = 0, loadY = 0;
    logic [CW-1:0] posX, posY;
    logic          dirX, dirY, tick, edgeX, edgeY;
    int            checks = 0, errors = 0;

    vga_motion_gen #(.COORD_W(CW), .X_MAX(XM), .Y_MAX(YM), .TICK_DIV(TD), .STEP_W(SW)) dut (
        .clk(clk), .rstN(rstN), .enable(enable), .modeX(modeX), .modeY(modeY),
        .stepX(stepX), .stepY(stepY), .load(load), .loadX(loadX), .loadY(loadY),
        .posX(posX), .posY(posY), .dirX(dirX), .dirY(dirY),
        .tick(tick), .edgeX(edgeX), .edgeY(edgeY)
    );

    always #5 clk = ~clk;

    // Reference: signed velocity with reflection about the last cell, or modulo wrap.
    task automatic move(input int p, input bit d, input int st, input bit mode, input int m,
                        output int np, output bit nd, output bit e);
        int v;
        np = p; nd = d; e = 0;
        if (st != 0) begin
            if (!mode) begin
                np = (p + st) % m;
                e  = (p + st) >= m;
            end else begin
                v  = d ? -st : st;
                np = p + v;
                if (!d && np >= m - 1) begin
                    np = 2 * (m - 1) - np; nd = 1; e = 1;
                end else if (d && np <= 0) begin
                    np = -np; nd = 0; e = 1;
                end
            end
        end
    endtask

    int m_cnt, m_x, m_y;
    bit m_dx, m_dy, m_tick, m_ex, m_ey;

    always @(posedge clk or negedge rstN) begin : model
        int nx, ny;
        bit ndx, ndy, ex, ey;
        if (!rstN) begin
            m_cnt <= 0; m_x <= 0; m_y <= 0; m_dx <= 0; m_dy <= 0;
            m_tick <= 0; m_ex <= 0; m_ey <= 0;
        end else if (load) begin
            m_cnt <= 0;
            m_x <= int'(loadX) > XM - 1 ? XM - 1 : int'(loadX);
            m_y <= int'(loadY) > YM - 1 ? YM - 1 : int'(loadY);
            m_dx <= 0; m_dy <= 0; m_tick <= 0; m_ex <= 0; m_ey <= 0;
        end else begin
            m_tick <= 0; m_ex <= 0; m_ey <= 0;
            if (enable) begin
                m_cnt <= m_cnt + 1;
                if ((m_cnt + 1) % TD == 0) begin
                    move(m_x, m_dx, int'(stepX), modeX, XM, nx, ndx, ex);
                    move(m_y, m_dy, int'(stepY), modeY, YM, ny, ndy, ey);
                    m_x <= nx; m_dx <= ndx; m_ex <= ex;
                    m_y <= ny; m_dy <= ndy; m_ey <= ey;
                    m_tick <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({posX, posY, dirX, dirY, tick, edgeX, edgeY} !==
            {16'(m_x), 16'(m_y), m_dx, m_dy, m_tick, m_ex, m_ey}) begin
            errors++;
            $display("FAIL model t=%0t: got x=%0d y=%0d dx=%0b dy=%0b t=%0b ex=%0b ey=%0b expected x=%0d y=%0d dx=%0b dy=%0b t=%0b ex=%0b ey=%0b",
                     $time, posX, posY, dirX, dirY, tick, edgeX, edgeY,
                     m_x, m_y, m_dx, m_dy, m_tick, m_ex, m_ey);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 20);
        if (!tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no tick after %0d clocks expected one", n);
        end
    endtask

    int n, cnt, px;
    int t1x[4] = '{3, 6, 9, 2};
    int t1e[4] = '{0, 0, 0, 1};
    int t2x[4] = '{9, 5, 1, 3};
    int t2dx[4] = '{1, 1, 1, 0};
    int t2ex[4] = '{1, 0, 0, 1};
    int t3y[4] = '{7, 0, 7, 0};
    int t3dy[4] = '{1, 0, 1, 0};

    initial begin
        enable = 1; stepX = 3;
        @(negedge clk);
        check("reset_posX", posX, 0);
        check("reset_tick", tick, 0);
        @(negedge clk);
        rstN = 1;
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            check("wrap_period", n, 4);
            check("wrap_posX", posX, t1x[i]);
            check("wrap_edgeX", edgeX, t1e[i]);
            check("wrap_posY", posY, 0);
        end
        modeX = 1; modeY = 1; stepX = 4; stepY = 7;
        load = 1; loadX = 5; loadY = 0;
        @(negedge clk);
        load = 0;
        check("load_posX", posX, 5);
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            check("bounce_period", n, 4);
            check("bounce_posX", posX, t2x[i]);
            check("bounce_dirX", dirX, t2dx[i]);
            check("bounce_edgeX", edgeX, t2ex[i]);
            check("bounce_posY", posY, t3y[i]);
            check("bounce_dirY", dirY, t3dy[i]);
            check("bounce_edgeY", edgeY, 1);
        end
        repeat (2) @(negedge clk);
        enable = 0;
        px = posX;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            cnt += tick;
        end
        check("frozen_ticks", cnt, 0);
        check("frozen_posX", posX, px);
        enable = 1;
        wait_tick(n);
        check("resume_period", n, 2);
        repeat (3) @(negedge clk);
        load = 1; loadX = 700; loadY = 3;
        @(negedge clk);
        load = 0;
        check("clamp_posX", posX, 9);
        check("clamp_posY", posY, 3);
        check("clamp_dirs", {dirX, dirY}, 0);
        check("clamp_tick", tick, 0);
        wait_tick(n);
        check("post_load_period", n, 4);
        check("post_load_posX", posX, 5);
        check("post_load_posY", posY, 4);
        #2 rstN = 0;
        #1;
        check("async_tick", tick, 0);
        check("async_edges", {edgeX, edgeY}, 0);
        check("async_pos", {posX, posY}, 0);
        check("async_dirs", {dirX, dirY}, 0);
        @(negedge clk);
        rstN = 1;
        wait_tick(n);
        check("post_reset_period", n, 4);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
